// File: rtl/epp_pixel_packer_if.sv
// epp_pixel_packer_if -- byte-in / pixel-out streaming bundle.
//   byte_valid/byte_data/byte_ready : EPP data-write bytes (R, G, B order)
//   pix_valid/pix_ready             : output pixel handshake
//   pix_data                        : {R[23:16], G[15:8], B[7:0]}
//   pix_sof/pix_eol/pix_eof         : position flags of the pixel on pix_data
// slave is the packer's view, master is the environment's view.
interface epp_pixel_packer_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        pix_valid;
    logic        pix_ready;
    logic [23:0] pix_data;
    logic        pix_sof;
    logic        pix_eol;
    logic        pix_eof;

    modport slave (
        input  byte_valid, byte_data, pix_ready,
        output byte_ready, pix_valid, pix_data, pix_sof, pix_eol, pix_eof
    );

    modport master (
        output byte_valid, byte_data, pix_ready,
        input  byte_ready, pix_valid, pix_data, pix_sof, pix_eol, pix_eof
    );
endinterface

// File: rtl/epp_pixel_packer.sv
// epp_pixel_packer -- packs R, G, B bytes from the EPP data port into 24-bit
// pixels with frame position flags and a single output register.
//   sys_clk     : clock, rising edge
//   sys_rst     : synchronous active-high reset
//   frame_start : one-cycle pulse, realigns the packer to pixel (0,0)
//   bus         : byte input and pixel output handshakes (slave modport)
//   frame_cnt   : frames completed (eof pixel handed off), wraps
//   err_sync    : sticky, frame_start seen while not at pixel (0,0) phase 0
module epp_pixel_packer #(
    parameter int H_ACTIVE = 1920,
    parameter int V_ACTIVE = 1080
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 frame_start,
    epp_pixel_packer_if.slave    bus,
    output logic [15:0]          frame_cnt,
    output logic                 err_sync
);
    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    // byte phase: which colour component the next accepted byte is
    localparam logic [1:0] PH_R = 2'd0;
    localparam logic [1:0] PH_G = 2'd1;
    localparam logic [1:0] PH_B = 2'd2;

    typedef struct packed {
        logic [23:0] data;
        logic        sof;
        logic        eol;
        logic        eof;
    } pix_t;

    logic [1:0]    phase_q, phase_d;
    logic [7:0]    r_q, r_d;
    logic [7:0]    g_q, g_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    pix_t          pix_q, pix_d;
    logic          pix_valid_q, pix_valid_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          err_sync_q, err_sync_d;

    logic byte_ready;
    logic byte_acc;
    logic pix_hs;

    // Phase 2 may only complete when the output register is free or being
    // drained this cycle; frame_start always blocks the byte it coincides with.
    assign byte_ready = !sys_rst && !frame_start &&
                        (phase_q != PH_B || !pix_valid_q || bus.pix_ready);
    assign byte_acc   = bus.byte_valid && byte_ready;
    assign pix_hs     = pix_valid_q && bus.pix_ready;

    always_comb begin
        phase_d     = phase_q;
        r_d         = r_q;
        g_d         = g_q;
        x_d         = x_q;
        y_d         = y_q;
        pix_d       = pix_q;
        pix_valid_d = pix_valid_q;
        frame_cnt_d = frame_cnt_q;
        err_sync_d  = err_sync_q;

        if (pix_hs) begin
            pix_valid_d = 1'b0;
            if (pix_q.eof) frame_cnt_d = frame_cnt_q + 16'd1;
        end

        if (frame_start) begin
            // Realign only; a pixel already in the output register is kept.
            if (phase_q != PH_R || x_q != '0 || y_q != '0) err_sync_d = 1'b1;
            phase_d = PH_R;
            x_d     = '0;
            y_d     = '0;
        end else if (byte_acc) begin
            case (phase_q)
                PH_R: begin
                    r_d     = bus.byte_data;
                    phase_d = PH_G;
                end
                PH_G: begin
                    g_d     = bus.byte_data;
                    phase_d = PH_B;
                end
                PH_B: begin
                    pix_d.data  = {r_q, g_q, bus.byte_data};
                    pix_d.sof   = (x_q == '0) && (y_q == '0);
                    pix_d.eol   = (x_q == X_LAST);
                    pix_d.eof   = (x_q == X_LAST) && (y_q == Y_LAST);
                    pix_valid_d = 1'b1;   // overrides a same-cycle drain
                    phase_d     = PH_R;
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
                default: phase_d = PH_R;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            phase_q     <= PH_R;
            r_q         <= '0;
            g_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            pix_q       <= '0;
            pix_valid_q <= 1'b0;
            frame_cnt_q <= '0;
            err_sync_q  <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            r_q         <= r_d;
            g_q         <= g_d;
            x_q         <= x_d;
            y_q         <= y_d;
            pix_q       <= pix_d;
            pix_valid_q <= pix_valid_d;
            frame_cnt_q <= frame_cnt_d;
            err_sync_q  <= err_sync_d;
        end
    end

    assign bus.byte_ready = byte_ready;
    assign bus.pix_valid  = pix_valid_q;
    assign bus.pix_data   = pix_q.data;
    assign bus.pix_sof    = pix_q.sof;
    assign bus.pix_eol    = pix_q.eol;
    assign bus.pix_eof    = pix_q.eof;
    assign frame_cnt      = frame_cnt_q;
    assign err_sync       = err_sync_q;
endmodule

// File: tb/tb_epp_pixel_packer.sv
module tb_epp_pixel_packer;
    localparam int H = 4;
    localparam int V = 2;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        frame_start;
    logic [15:0] frame_cnt;
    logic        err_sync;

    epp_pixel_packer_if bif ();

    epp_pixel_packer #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .frame_start (frame_start),
        .bus         (bif.slave),
        .frame_cnt   (frame_cnt),
        .err_sync    (err_sync)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [23:0] d;
        logic        s;
        logic        l;
        logic        f;
    } exp_t;

    typedef struct {
        logic [7:0] r, g, b;
        logic       sof, eol, eof;
    } vec_t;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    // position model of the stream, used to predict scoreboard entries
    int         m_phase, m_x, m_y;
    logic [7:0] m_r, m_g;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_x     = 0;
        m_y     = 0;
    endtask

    task automatic model_accept(input logic [7:0] b);
        exp_t e;
        case (m_phase)
            0: begin m_r = b; m_phase = 1; end
            1: begin m_g = b; m_phase = 2; end
            default: begin
                e.d = {m_r, m_g, b};
                e.s = (m_x == 0) && (m_y == 0);
                e.l = (m_x == H - 1);
                e.f = (m_x == H - 1) && (m_y == V - 1);
                exp_q.push_back(e);
                m_phase = 0;
                if (m_x == H - 1) begin
                    m_x = 0;
                    m_y = (m_y == V - 1) ? 0 : m_y + 1;
                end else begin
                    m_x++;
                end
            end
        endcase
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bit acc = 0;
        bif.byte_valid = 1'b1;
        bif.byte_data  = b;
        while (!acc && n < 50) begin
            @(negedge sys_clk);
            acc = bif.byte_ready;
            step();
            n++;
        end
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL byte_timeout: byte %h not accepted in 50 cycles", b);
        end else begin
            model_accept(b);
        end
    endtask

    task automatic idle(input int n);
        bif.byte_valid = 1'b0;
        repeat (n) step();
    endtask

    // scoreboard: every output handshake must match the oldest prediction
    always @(negedge sys_clk) begin
        if (!sys_rst && bif.pix_valid && bif.pix_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL pix_unexpected: got %h with no pixel expected", bif.pix_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pix_out", {5'd0, bif.pix_data, bif.pix_sof, bif.pix_eol, bif.pix_eof},
                    {5'd0, e});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl[9];

    initial begin
        tbl[0] = '{8'h11, 8'h22, 8'h33, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'h41, 8'h42, 8'h43, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{8'h51, 8'h52, 8'h53, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{8'h61, 8'h62, 8'h63, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{8'h71, 8'h72, 8'h73, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{8'h81, 8'h82, 8'h83, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{8'h91, 8'h92, 8'h93, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{8'hA1, 8'hA2, 8'hA3, 1'b0, 1'b1, 1'b1};
        tbl[8] = '{8'hB1, 8'hB2, 8'hB3, 1'b1, 1'b0, 1'b0};

        sys_rst        = 1'b1;
        frame_start    = 1'b0;
        bif.byte_valid = 1'b0;
        bif.byte_data  = 8'h00;
        bif.pix_ready  = 1'b1;
        model_reset();
        repeat (3) step();

        // reset state
        @(negedge sys_clk);
        chk("rst_byte_ready", {31'd0, bif.byte_ready}, 32'd0);
        chk("rst_pix", {bif.pix_valid, bif.pix_sof, bif.pix_eol, bif.pix_eof, bif.pix_data}, 32'd0);
        chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("rst_err_sync", {31'd0, err_sync}, 32'd0);
        step();
        sys_rst = 1'b0;
        step();

        // continuous stream of one full frame plus the first pixel of the next
        for (int i = 0; i < 9; i++) begin
            send_byte(tbl[i].r);
            send_byte(tbl[i].g);
            send_byte(tbl[i].b);
            // one cycle after the third byte the pixel is on the output
            chk($sformatf("tbl_pix%0d", i),
                {4'd0, bif.pix_valid, bif.pix_sof, bif.pix_eol, bif.pix_eof, bif.pix_data},
                {4'd0, 1'b1, tbl[i].sof, tbl[i].eol, tbl[i].eof, tbl[i].r, tbl[i].g, tbl[i].b});
            if (i == 7) chk("frame_cnt_pre_eof_hs", {16'd0, frame_cnt}, 32'd0);
        end
        chk("frame_cnt_after_frame", {16'd0, frame_cnt}, 32'd1);
        chk("err_sync_clean", {31'd0, err_sync}, 32'd0);
        idle(3);
        chk("sb_empty_1", exp_q.size(), 32'd0);

        // backpressure: held pixel, phase-2 byte stalls, then back-to-back drain
        bif.pix_ready = 1'b0;
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
        send_byte(8'hB1); send_byte(8'hB2);
        bif.byte_valid = 1'b1;
        bif.byte_data  = 8'hB3;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            chk("stall_byte_ready", {31'd0, bif.byte_ready}, 32'd0);
            chk("stall_hold", {7'd0, bif.pix_valid, bif.pix_data}, {7'd0, 1'b1, 24'hA1A2A3});
            step();
        end
        bif.pix_ready = 1'b1;
        @(negedge sys_clk);
        chk("drain_byte_ready", {31'd0, bif.byte_ready}, 32'd1);
        step();
        model_accept(8'hB3);
        chk("b2b_pix", {7'd0, bif.pix_valid, bif.pix_data}, {7'd0, 1'b1, 24'hB1B2B3});

        // frame_start after two bytes of a pixel, coincident with a byte
        send_byte(8'hC1); send_byte(8'hC2);
        frame_start    = 1'b1;
        bif.byte_valid = 1'b1;
        bif.byte_data  = 8'hC3;
        @(negedge sys_clk);
        chk("fs_byte_ready", {31'd0, bif.byte_ready}, 32'd0);
        step();
        frame_start = 1'b0;
        model_reset();
        chk("err_sync_set", {31'd0, err_sync}, 32'd1);
        send_byte(8'hD1); send_byte(8'hD2); send_byte(8'hD3);
        chk("fs_sof", {7'd0, bif.pix_sof, bif.pix_data}, {7'd0, 1'b1, 24'hD1D2D3});
        idle(3);
        chk("sb_empty_2", exp_q.size(), 32'd0);

        // reset mid-frame with a pixel held and a partial byte accepted
        bif.pix_ready = 1'b0;
        send_byte(8'hE1); send_byte(8'hE2); send_byte(8'hE3);
        send_byte(8'hF1);
        bif.byte_valid = 1'b0;
        sys_rst = 1'b1;
        step();
        @(negedge sys_clk);
        chk("mid_rst_byte_ready", {31'd0, bif.byte_ready}, 32'd0);
        chk("mid_rst_pix", {bif.pix_valid, bif.pix_sof, bif.pix_eol, bif.pix_eof, bif.pix_data}, 32'd0);
        chk("mid_rst_cnt_err", {15'd0, err_sync, frame_cnt}, 32'd0);
        step();
        sys_rst = 1'b0;
        exp_q.delete();
        model_reset();
        bif.pix_ready = 1'b1;
        step();
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        chk("post_rst_sof", {7'd0, bif.pix_sof, bif.pix_data}, {7'd0, 1'b1, 24'h010203});
        idle(3);
        chk("sb_empty_3", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/epp_pixel_packer.md
EPP_PIXEL_PACKER -- requirements
Module: epp_pixel_packer

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1920, active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 1080, active lines per frame.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 sys_clk  in  1  single clock; all logic on rising edge.
REQ-005 sys_rst  in  1  synchronous active-high reset.
REQ-006 frame_start  in  1  one-cycle pulse from EPP register decode; realigns to pixel (0,0).
REQ-007 byte_valid  in  1  EPP data-write byte available.
REQ-008 byte_data  in  8  EPP data-write byte.
REQ-009 byte_ready  out  1  byte accepted when byte_valid && byte_ready.
REQ-010 pix_valid  out  1  output pixel valid.
REQ-011 pix_ready  in  1  downstream accepts pixel when pix_valid && pix_ready.
REQ-012 pix_data  out  24  packed pixel {R[23:16],G[15:8],B[7:0]}.
REQ-013 pix_sof  out  1  pixel is (x=0,y=0).
REQ-014 pix_eol  out  1  pixel is x=H_ACTIVE-1.
REQ-015 pix_eof  out  1  pixel is (x=H_ACTIVE-1,y=V_ACTIVE-1).
REQ-016 frame_cnt  out  16  completed frames, wraps 0xFFFF->0.
REQ-017 err_sync  out  1  sticky: frame_start arrived mid-frame or mid-pixel.

Function
REQ-018 SHALL accept bytes in order R, G, B; byte phase counter 0->1->2->0.
REQ-019 SHALL drive byte_ready=1 in phases 0 and 1, and in phase 2 only when !pix_valid || pix_ready; byte_ready=0 in any cycle frame_start=1.
REQ-020 SHALL, on acceptance of a phase-2 byte, register pix_data={R,G,byte_data} and flags, set pix_valid next cycle (latency 1 cycle from third byte).
REQ-021 SHALL hold pix_data and flags stable while pix_valid && !pix_ready; never deassert pix_valid without a handshake.
REQ-022 SHALL clear pix_valid after handshake unless a new pixel loads the same cycle (back-to-back: valid stays 1, data updates).
REQ-023 SHALL keep pixel counters x (0..H_ACTIVE-1) and y (0..V_ACTIVE-1) that advance when a pixel is loaded into the output register.
REQ-024 SHALL wrap x at H_ACTIVE-1 to 0 and increment y; wrap y at V_ACTIVE-1 to 0.
REQ-025 SHALL increment frame_cnt on the handshake of a pixel with pix_eof=1.
REQ-026 frame_start SHALL reset phase, x, y to 0 and discard partial R/G bytes; a pixel already in the output register stays valid and unchanged.
REQ-027 SHALL set err_sync when frame_start=1 and (phase!=0 or x!=0 or y!=0); cleared only by sys_rst.
REQ-028 frame_start coincident with byte_valid: byte not accepted (byte_ready=0), counters reset.
REQ-029 counter widths SHALL be clog2 of the parameters; no truncation at 1920/1080.

Reset
REQ-030 sys_rst=1 SHALL force pix_valid=0, pix_data=0, pix_sof=pix_eol=pix_eof=0, frame_cnt=0, err_sync=0, phase=0, x=y=0, byte_ready=0 during reset.
REQ-031 sys_rst mid-pixel or mid-frame SHALL discard partial bytes and any held pixel; first pixel after release is sof.

Verification (H_ACTIVE=4, V_ACTIVE=2 unless stated)
REQ-032 Bytes 0x11,0x22,0x33 with pix_ready=1 -> pix_valid=1 one cycle after 0x33, pix_data=0x112233, pix_sof=1.
REQ-033 Stream 24 bytes continuous, pix_ready=1 -> 8 pixels; eol on pixels 4 and 8, eof on pixel 8, frame_cnt 0->1; 9th pixel sof=1.
REQ-034 pix_ready=0 with a pixel held, feed 5 bytes -> byte_ready drops in phase 2, held pixel unchanged; pix_ready=1 -> both pixels delivered in order, none lost.
REQ-035 frame_start after 2 bytes of pixel 3 -> err_sync=1, partial discarded, next 3 bytes emerge with pix_sof=1.
REQ-036 sys_rst pulsed mid-frame with pixel held -> all outputs 0, frame_cnt=0, err_sync=0; next pixel sof=1.
REQ-037 Defaults 1920x1080, 6220800 bytes -> exactly one eof, frame_cnt=1, x/y wrap without overflow.
